// File: rtl/sb_pkg.sv
// Shared sizing, slot payload and constants for the register-writer scoreboard.
package sb_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned CNT_W    = 2;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dst;
    logic             ld;
  } slot_t;

endpackage

// File: rtl/reg_writer_scoreboard_if.sv
// Decode-side bus between the ID stage and the register-writer scoreboard.
interface reg_writer_scoreboard_if;
  import sb_pkg::*;

  logic                id_valid;
  logic                id_regwrite;
  logic                id_is_load;
  logic                id_is_store;
  logic [REG_W-1:0]    id_dst;
  logic [REG_W-1:0]    id_src1;
  logic [REG_W-1:0]    id_src2;
  logic                id_src1_used;
  logic                id_src2_used;
  logic                flush;
  logic                mem_stall;
  logic                hlt_id;
  logic                stall_id;
  logic                bubble_ex;
  logic [NUM_REGS-1:0] pend_mask;
  logic                drained;
  logic                sb_err;

  modport master (
    output id_valid, id_regwrite, id_is_load, id_is_store, id_dst, id_src1, id_src2,
           id_src1_used, id_src2_used, flush, mem_stall, hlt_id,
    input  stall_id, bubble_ex, pend_mask, drained, sb_err
  );

  modport slave (
    input  id_valid, id_regwrite, id_is_load, id_is_store, id_dst, id_src1, id_src2,
           id_src1_used, id_src2_used, flush, mem_stall, hlt_id,
    output stall_id, bubble_ex, pend_mask, drained, sb_err
  );

endinterface

// File: rtl/sb_counter.sv
// In-flight writer count for one register; saturates and flags a sticky error on misuse.
module sb_counter
  import sb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic inc,
  input  logic dec,
  output logic pend,
  output logic err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;

  // Simultaneous inc and dec cancel: one writer enters as another retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (en) begin
      if (inc && !dec) begin
        if (cnt == CNT_MAX) err <= 1'b1;
        else                cnt <= cnt + CNT_W'(1);
      end else if (dec && !inc) begin
        if (cnt == '0) err <= 1'b1;
        else           cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign pend = (cnt != '0);

endmodule

// File: rtl/reg_writer_scoreboard.sv
// Tracks register writers through EX/MEM/WB; raises load-use stalls, pending mask and HLT drain.
module reg_writer_scoreboard
  import sb_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  reg_writer_scoreboard_if.slave        bus
);

  slot_t exS, memS, wbS;
  logic  hltSeen;
  logic  loadUse;
  logic  stallC;
  logic  insert;
  logic  advance;
  logic  [NUM_REGS-1:0] pendMask;
  logic  [NUM_REGS-1:0] cntErr;
  logic  unusedWbLd;

  // Store data sourced from the load is covered by MEM-to-MEM forwarding, so only src1 counts for SW.
  always_comb begin
    loadUse = exS.v & exS.ld & bus.id_valid &
              ((bus.id_src1_used & (bus.id_src1 == exS.dst)) |
               (bus.id_src2_used & ~bus.id_is_store & (bus.id_src2 == exS.dst)));
    stallC  = loadUse & ~bus.flush;
    advance = ~bus.mem_stall;
    insert  = bus.id_valid & bus.id_regwrite & (bus.id_dst != ZERO_REG) &
              ~loadUse & ~bus.flush & ~hltSeen;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exS     <= '0;
      memS    <= '0;
      wbS     <= '0;
      hltSeen <= 1'b0;
    end else if (advance) begin
      wbS  <= memS;
      memS <= exS;
      exS  <= insert ? '{v: 1'b1, dst: bus.id_dst, ld: bus.id_is_load} : '0;
      if (bus.hlt_id && bus.id_valid && !bus.flush && !loadUse) hltSeen <= 1'b1;
    end
  end

  assign pendMask[0] = 1'b0;
  assign cntErr[0]   = 1'b0;

  for (genvar r = 1; r < int'(NUM_REGS); r++) begin : g_cnt
    sb_counter u_cnt (
      .clk  (clk),
      .rst  (rst),
      .en   (advance),
      .inc  (insert && (bus.id_dst == REG_W'(r))),
      .dec  (wbS.v && (wbS.dst == REG_W'(r))),
      .pend (pendMask[r]),
      .err  (cntErr[r])
    );
  end

  assign unusedWbLd    = wbS.ld;

  assign bus.stall_id  = stallC;
  assign bus.bubble_ex = stallC | bus.flush;
  assign bus.pend_mask = pendMask;
  assign bus.drained   = hltSeen & ~exS.v & ~memS.v & ~wbS.v;
  assign bus.sb_err    = |cntErr;

endmodule

// File: tb/tb_reg_writer_scoreboard.sv
// Directed and randomized checks of reg_writer_scoreboard against an in-flight-list model.
module tb_reg_writer_scoreboard;
  import sb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_writer_scoreboard_if bus ();

  reg_writer_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit valid, rw, ld, st, u1, u2, flush, ms, hlt;
    int dst, s1, s2;
  } in_t;

  // Model: each accepted writer carries its age in edges; it is gone once age reaches 3.
  typedef struct {
    int dst;
    bit ld;
    int age;
  } rec_t;

  rec_t recs[$];
  bit   mHlt;
  int   nChecks = 0;
  int   nPass   = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic in_t idle();
    in_t i;
    i = '{default: 0};
    return i;
  endfunction

  function automatic in_t alu(int d, int a, int b);
    in_t i = idle();
    i.valid = 1; i.rw = 1; i.dst = d; i.s1 = a; i.s2 = b; i.u1 = 1; i.u2 = 1;
    return i;
  endfunction

  function automatic in_t lw(int d, int base);
    in_t i = idle();
    i.valid = 1; i.rw = 1; i.ld = 1; i.dst = d; i.s1 = base; i.u1 = 1;
    return i;
  endfunction

  function automatic in_t sw(int addr, int data);
    in_t i = idle();
    i.valid = 1; i.st = 1; i.s1 = addr; i.s2 = data; i.u1 = 1; i.u2 = 1;
    return i;
  endfunction

  function automatic in_t hlt();
    in_t i = idle();
    i.valid = 1; i.hlt = 1;
    return i;
  endfunction

  function automatic bit modelLu(in_t i);
    foreach (recs[k])
      if (recs[k].age == 0 && recs[k].ld && i.valid &&
          ((i.u1 && i.s1 == recs[k].dst) || (i.u2 && !i.st && i.s2 == recs[k].dst)))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NUM_REGS-1:0] modelPend();
    logic [NUM_REGS-1:0] m = '0;
    foreach (recs[k]) m[recs[k].dst] = 1'b1;
    return m;
  endfunction

  task automatic modelEdge(input in_t i, input bit lu);
    rec_t keep[$];
    bit   ins;
    if (i.ms) return;
    ins = i.valid && i.rw && i.dst != 0 && !lu && !i.flush && !mHlt;
    if (i.hlt && i.valid && !i.flush && !lu) mHlt = 1;
    foreach (recs[k]) begin
      rec_t r = recs[k];
      r.age++;
      if (r.age < 3) keep.push_back(r);
    end
    recs = keep;
    if (ins) recs.push_back('{dst: i.dst, ld: i.ld, age: 0});
  endtask

  task automatic drive(input in_t i);
    bus.id_valid     = i.valid;
    bus.id_regwrite  = i.rw;
    bus.id_is_load   = i.ld;
    bus.id_is_store  = i.st;
    bus.id_dst       = REG_W'(i.dst);
    bus.id_src1      = REG_W'(i.s1);
    bus.id_src2      = REG_W'(i.s2);
    bus.id_src1_used = i.u1;
    bus.id_src2_used = i.u2;
    bus.flush        = i.flush;
    bus.mem_stall    = i.ms;
    bus.hlt_id       = i.hlt;
  endtask

  task automatic checkState();
    checkVal("pend_mask", 32'(bus.pend_mask), 32'(modelPend()));
    checkVal("drained", 32'(bus.drained), 32'(mHlt && recs.size() == 0));
    checkVal("sb_err", 32'(bus.sb_err), 32'd0);
  endtask

  // One decode cycle: check state, drive, check hazard outputs, advance model at the edge.
  task automatic step(input in_t i);
    bit lu;
    @(negedge clk);
    checkState();
    drive(i);
    #1;
    lu = modelLu(i);
    checkVal("stall_id", 32'(bus.stall_id), 32'(lu && !i.flush));
    checkVal("bubble_ex", 32'(bus.bubble_ex), 32'((lu && !i.flush) || i.flush));
    @(posedge clk);
    modelEdge(i, lu);
  endtask

  task automatic idleN(input int n);
    for (int k = 0; k < n; k++) step(idle());
  endtask

  task automatic midReset();
    @(negedge clk);
    drive(idle());
    #2 rst = 1'b1;
    #1;
    checkVal("rst_pend_mask", 32'(bus.pend_mask), 32'd0);
    checkVal("rst_drained", 32'(bus.drained), 32'd0);
    checkVal("rst_stall_id", 32'(bus.stall_id), 32'd0);
    recs.delete();
    mHlt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    in_t i;
    drive(idle());
    mHlt = 0;
    #12;
    checkVal("reset_stall_id", 32'(bus.stall_id), 32'd0);
    checkVal("reset_bubble_ex", 32'(bus.bubble_ex), 32'd0);
    checkVal("reset_pend_mask", 32'(bus.pend_mask), 32'd0);
    checkVal("reset_drained", 32'(bus.drained), 32'd0);
    checkVal("reset_sb_err", 32'(bus.sb_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load-use into ALU: stall once, then the held ADD goes in.
    step(lw(3, 1));
    i = alu(4, 3, 1);
    step(i);
    step(i);
    idleN(4);

    // Store data from load: no stall; store address from load: one stall.
    step(lw(3, 1));
    step(sw(5, 3));
    step(lw(3, 1));
    i = sw(3, 6);
    step(i);
    step(i);
    idleN(4);

    // Three writers to R2, then a fourth as the first retires.
    step(alu(2, 1, 1));
    step(alu(2, 1, 1));
    step(alu(2, 1, 1));
    step(alu(2, 1, 1));
    idleN(5);

    // Flush alongside a dependent instruction.
    step(lw(3, 1));
    i = alu(4, 3, 1);
    i.flush = 1;
    step(i);
    idleN(4);

    // Freeze with writers in every slot.
    step(alu(1, 0, 0));
    step(lw(2, 0));
    step(alu(3, 0, 0));
    i = alu(5, 3, 3);
    i.ms = 1;
    for (int k = 0; k < 4; k++) step(i);
    idleN(5);

    // HLT drain then asynchronous reset.
    step(alu(7, 1, 1));
    step(hlt());
    step(alu(6, 1, 1));
    idleN(5);
    midReset();
    step(lw(4, 1));
    midReset();
    idleN(2);

    // Randomized traffic with periodic resets.
    for (int n = 0; n < 800; n++) begin
      i = idle();
      i.valid = ($urandom_range(99) < 80);
      i.st    = ($urandom_range(99) < 15);
      i.rw    = !i.st && ($urandom_range(99) < 75);
      i.ld    = i.rw && ($urandom_range(99) < 35);
      i.dst   = $urandom_range(7);
      i.s1    = $urandom_range(7);
      i.s2    = $urandom_range(7);
      i.u1    = ($urandom_range(99) < 80);
      i.u2    = i.st || ($urandom_range(99) < 60);
      i.flush = ($urandom_range(99) < 8);
      i.ms    = ($urandom_range(99) < 15);
      i.hlt   = ($urandom_range(99) < 2);
      step(i);
      if (n % 60 == 59) midReset();
    end

    idleN(2);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
